// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: PC register, imem fetch handshake, IF/ID register.
// Optional FETCH_STATS_EN adds saturating flush/stall cycle counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        IF_Flush,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_instr,
   output logic        o_dbg_state
`ifdef FETCH_STATS_EN
   ,
   output logic [15:0] stat_flush_cnt,
   output logic [15:0] stat_stall_cnt
`endif
);

   typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic        r_ifid_valid, w_ifid_valid_nxt;
   logic [31:0] r_ifid_pc, w_ifid_pc_nxt;
   logic [31:0] r_ifid_pc4, w_ifid_pc4_nxt;
   logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
   logic [31:0] r_buf_pc, w_buf_pc_nxt;
   logic [31:0] r_buf_instr, w_buf_instr_nxt;
   logic [31:0] w_pc_plus4;
   logic        w_unused_redirect_lsbs;

   // Handshake: imem_req is high in FETCH; imem_ready in a cycle means imem_rdata is the
   // word at this cycle's imem_addr. Nothing is outstanding once the address moves on.
   assign imem_req    = rst_n & (r_state == S_FETCH);
   assign imem_addr   = r_pc;
   assign ifid_valid  = r_ifid_valid;
   assign ifid_pc     = r_ifid_pc;
   assign ifid_pc4    = r_ifid_pc4;
   assign ifid_instr  = r_ifid_instr;
   assign o_dbg_state = r_state;

   assign w_pc_plus4             = r_pc + 32'd4;
   assign w_unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_ifid_valid_nxt = r_ifid_valid;
      w_ifid_pc_nxt    = r_ifid_pc;
      w_ifid_pc4_nxt   = r_ifid_pc4;
      w_ifid_instr_nxt = r_ifid_instr;
      w_buf_pc_nxt     = r_buf_pc;
      w_buf_instr_nxt  = r_buf_instr;

      if (IF_Flush) begin
         // Redirect beats stall, ready and state; any same-cycle response is dropped.
         w_ifid_valid_nxt = 1'b0;
         w_ifid_instr_nxt = NOP_INSTR;
         w_pc_nxt         = {redirect_pc[31:2], 2'b00};
         w_buf_pc_nxt     = 32'd0;
         w_buf_instr_nxt  = NOP_INSTR;
         w_state_nxt      = S_FETCH;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_ready && !stall) begin
                  w_ifid_valid_nxt = 1'b1;
                  w_ifid_pc_nxt    = r_pc;
                  w_ifid_pc4_nxt   = w_pc_plus4;
                  w_ifid_instr_nxt = imem_rdata;
                  w_pc_nxt         = w_pc_plus4;
               end else if (imem_ready && stall) begin
                  w_buf_pc_nxt    = r_pc;
                  w_buf_instr_nxt = imem_rdata;
                  w_state_nxt     = S_HOLD;
               end else if (!imem_ready && !stall) begin
                  w_ifid_valid_nxt = 1'b0;
                  w_ifid_instr_nxt = NOP_INSTR;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  w_ifid_valid_nxt = 1'b1;
                  w_ifid_pc_nxt    = r_buf_pc;
                  w_ifid_pc4_nxt   = r_buf_pc + 32'd4;
                  w_ifid_instr_nxt = r_buf_instr;
                  w_pc_nxt         = w_pc_plus4;
                  w_state_nxt      = S_FETCH;
               end
            end
            default: w_state_nxt = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_FETCH;
         r_pc         <= RESET_PC;
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= 32'd0;
         r_ifid_pc4   <= 32'd0;
         r_ifid_instr <= NOP_INSTR;
         r_buf_pc     <= 32'd0;
         r_buf_instr  <= NOP_INSTR;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_ifid_valid <= w_ifid_valid_nxt;
         r_ifid_pc    <= w_ifid_pc_nxt;
         r_ifid_pc4   <= w_ifid_pc4_nxt;
         r_ifid_instr <= w_ifid_instr_nxt;
         r_buf_pc     <= w_buf_pc_nxt;
         r_buf_instr  <= w_buf_instr_nxt;
      end
   end

`ifdef FETCH_STATS_EN
   logic [15:0] r_flush_cnt;
   logic [15:0] r_stall_cnt;

   assign stat_flush_cnt = r_flush_cnt;
   assign stat_stall_cnt = r_stall_cnt;

   // Stall cycles are only those not overridden by a flush; both counters saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flush_cnt <= 16'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         if (IF_Flush && (r_flush_cnt != 16'hFFFF))
            r_flush_cnt <= r_flush_cnt + 16'd1;
         if (stall && !IF_Flush && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with hand-computed expectations.
// Memory model answers imem_addr ^ 32'hA5A5_0000 combinationally.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        IF_Flush;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_instr;
   logic        o_dbg_state;
`ifdef FETCH_STATS_EN
   logic [15:0] stat_flush_cnt;
   logic [15:0] stat_stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .IF_Flush    (IF_Flush),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .ifid_valid  (ifid_valid),
      .ifid_pc     (ifid_pc),
      .ifid_pc4    (ifid_pc4),
      .ifid_instr  (ifid_instr),
      .o_dbg_state (o_dbg_state)
`ifdef FETCH_STATS_EN
      ,
      .stat_flush_cnt (stat_flush_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb imem_rdata = imem_addr ^ 32'hA5A5_0000;

   typedef struct packed {
      logic        stall;
      logic        flush;
      logic [31:0] redir;
      logic        ready;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(logic s, logic f, logic [31:0] r, logic rd,
                               logic rq, logic [31:0] a, logic v,
                               logic [31:0] p, logic [31:0] i);
      vec_t t;
      t.stall = s; t.flush = f; t.redir = r; t.ready = rd;
      t.e_req = rq; t.e_addr = a; t.e_valid = v; t.e_pc = p; t.e_instr = i;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic v, input logic [31:0] p,
                           input logic [31:0] i);
      logic [31:0] p4;
      p4 = p + 32'd4;
      chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
      chk({tag, ".pc"}, ifid_pc, p);
      chk({tag, ".pc4"}, ifid_pc4, p4);
      chk({tag, ".instr"}, ifid_instr, i);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".req"}, {31'd0, imem_req}, 32'd0);
      chk({tag, ".addr"}, imem_addr, 32'd0);
      chk({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
      chk({tag, ".pc"}, ifid_pc, 32'd0);
      chk({tag, ".pc4"}, ifid_pc4, 32'd0);
      chk({tag, ".instr"}, ifid_instr, NOP);
      chk({tag, ".state"}, {31'd0, o_dbg_state}, 32'd0);
   endtask

   // driver: inputs set just after a rising edge
   task automatic drive(input logic s, input logic f, input logic [31:0] r, input logic rd);
      stall = s; IF_Flush = f; redirect_pc = r; imem_ready = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 1'b0);

      vecs[0]  = mk(0, 0, 32'h0,        1, 1, 32'h0,        1, 32'h0,        32'hA5A5_0000);
      vecs[1]  = mk(0, 0, 32'h0,        1, 1, 32'h4,        1, 32'h4,        32'hA5A5_0004);
      vecs[2]  = mk(0, 0, 32'h0,        0, 1, 32'h8,        0, 32'h4,        NOP);
      vecs[3]  = mk(0, 0, 32'h0,        0, 1, 32'h8,        0, 32'h4,        NOP);
      vecs[4]  = mk(0, 0, 32'h0,        1, 1, 32'h8,        1, 32'h8,        32'hA5A5_0008);
      vecs[5]  = mk(1, 0, 32'h0,        1, 1, 32'hC,        1, 32'h8,        32'hA5A5_0008);
      vecs[6]  = mk(1, 0, 32'h0,        1, 0, 32'hC,        1, 32'h8,        32'hA5A5_0008);
      vecs[7]  = mk(1, 0, 32'h0,        1, 0, 32'hC,        1, 32'h8,        32'hA5A5_0008);
      vecs[8]  = mk(0, 0, 32'h0,        1, 0, 32'hC,        1, 32'hC,        32'hA5A5_000C);
      vecs[9]  = mk(0, 0, 32'h0,        1, 1, 32'h10,       1, 32'h10,       32'hA5A5_0010);
      vecs[10] = mk(1, 0, 32'h0,        1, 1, 32'h14,       1, 32'h10,       32'hA5A5_0010);
      vecs[11] = mk(1, 1, 32'h103,      1, 0, 32'h14,       0, 32'h10,       NOP);
      vecs[12] = mk(0, 0, 32'h0,        1, 1, 32'h100,      1, 32'h100,      32'hA5A5_0100);
      vecs[13] = mk(0, 1, 32'h203,      1, 1, 32'h104,      0, 32'h100,      NOP);
      vecs[14] = mk(1, 1, 32'h301,      0, 1, 32'h200,      0, 32'h100,      NOP);
      vecs[15] = mk(0, 0, 32'h0,        1, 1, 32'h300,      1, 32'h300,      32'hA5A5_0300);
      vecs[16] = mk(1, 0, 32'h0,        0, 1, 32'h304,      1, 32'h300,      32'hA5A5_0300);
      vecs[17] = mk(0, 1, 32'hFFFF_FFFF, 0, 1, 32'h304,     0, 32'h300,      NOP);
      vecs[18] = mk(0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
      vecs[19] = mk(0, 0, 32'h0,        1, 1, 32'h0,        1, 32'h0,        32'hA5A5_0000);
      vecs[20] = mk(1, 0, 32'h0,        1, 1, 32'h4,        1, 32'h0,        32'hA5A5_0000);
      vecs[21] = mk(1, 0, 32'h0,        1, 0, 32'h4,        1, 32'h0,        32'hA5A5_0000);

      tick();
      tick();
      chk_reset("rst");
      rst_n = 1'b1;

      for (int k = 0; k < 22; k++) begin
         drive(vecs[k].stall, vecs[k].flush, vecs[k].redir, vecs[k].ready);
         #1;
         chk($sformatf("v%0d.req", k), {31'd0, imem_req}, {31'd0, vecs[k].e_req});
         chk($sformatf("v%0d.addr", k), imem_addr, vecs[k].e_addr);
         tick();
         chk_ifid($sformatf("v%0d", k), vecs[k].e_valid, vecs[k].e_pc, vecs[k].e_instr);
      end

      // asynchronous reset while in HOLD (stall still high)
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("arst");
      tick();
      chk_reset("arst_held");
`ifdef FETCH_STATS_EN
      chk("stat_flush_rst", {16'd0, stat_flush_cnt}, 32'd0);
      chk("stat_stall_rst", {16'd0, stat_stall_cnt}, 32'd0);
`endif
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      rst_n = 1'b1;
      #1;
      chk("post_rst.req", {31'd0, imem_req}, 32'd1);
      chk("post_rst.addr", imem_addr, 32'd0);
      tick();
      chk_ifid("post_rst", 1'b1, 32'd0, 32'hA5A5_0000);

`ifdef FETCH_STATS_EN
      drive(1'b0, 1'b1, 32'h40, 1'b1);
      repeat (3) tick();
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      repeat (5) tick();
      chk("stat_flush_3", {16'd0, stat_flush_cnt}, 32'd3);
      chk("stat_stall_5", {16'd0, stat_stall_cnt}, 32'd5);
      repeat (70000) tick();
      chk("stat_stall_sat", {16'd0, stat_stall_cnt}, 32'h0000_FFFF);
      chk("stat_flush_hold", {16'd0, stat_flush_cnt}, 32'd3);
      drive(1'b0, 1'b0, 32'd0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
